// File: rtl/systolic_tile_feeder.sv
// systolic_tile_feeder
//
// Feeds one tile of K column vectors into the systolic skew bank. Each tile
// starts with a clear beat that resets the bank, then forwards every
// accepted vector as an advance beat. After that it appends N-1 zero beats
// so the deepest skew lane drains, and it ends with a one-cycle Done pulse.
//
// Parameters
//   N           array dimension (rows per vector, number of skew lanes)
//   DATA_WIDTH  signed element width; rows pass through bit-exact
//   K_MAX       largest tile depth; a longer K_Len saturates to K_MAX
//
// Ports
//   CLK         rising-edge clock
//   ASYNC_RST   asynchronous active-high reset
//   SYNC_RST    synchronous abort; returns to IDLE and zeroes all outputs
//   Start/K_Len tile request; only looked at while not Busy
//   In_Valid/In_Ready/In_Data   upstream vector stream (row r at [r*DW +: DW])
//   Out_Valid   skew bank advance enable
//   Skew_Clear  skew bank synchronous clear (only ever with Out_Valid)
//   Out_Data    vector presented to the skew bank
//   Busy        tile in progress
//   Done        one-cycle tile-complete pulse
module systolic_tile_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int K_MAX      = 256,
  localparam int CW        = $clog2(K_MAX + 1)
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  input  logic                    SYNC_RST,
  input  logic                    Start,
  input  logic [CW-1:0]           K_Len,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [N*DATA_WIDTH-1:0] In_Data,
  output logic                    Out_Valid,
  output logic                    Skew_Clear,
  output logic [N*DATA_WIDTH-1:0] Out_Data,
  output logic                    Busy,
  output logic                    Done
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] K_LIM = CW'(K_MAX);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             k, k_n;
  logic [CW-1:0]             beat, beat_n;
  logic [CW-1:0]             beat_inc;
  logic [FW-1:0]             flush, flush_n;
  logic                      ov_n, sc_n, done_n;
  logic [N*DATA_WIDTH-1:0]   od_n;

  function automatic logic [CW-1:0] sat_k(input logic [CW-1:0] len);
    return (len > K_LIM) ? K_LIM : len;
  endfunction

  assign In_Ready = (state == LOAD);
  assign Busy     = (state == CLEAR) || (state == LOAD) || (state == FLUSH);
  assign beat_inc = beat + 1'b1;

  always_comb begin
    state_n = state;
    k_n     = k;
    beat_n  = beat;
    flush_n = flush;
    ov_n    = 1'b0;
    sc_n    = 1'b0;
    od_n    = '0;
    done_n  = 1'b0;

    unique case (state)
      // DONE is not Busy, so a new tile may be requested in the Done cycle.
      IDLE, DONE: begin
        state_n = IDLE;
        if (Start) begin
          k_n    = sat_k(K_Len);
          beat_n = '0;
          if (sat_k(K_Len) == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = CLEAR;
            ov_n    = 1'b1;
            sc_n    = 1'b1;
          end
        end
      end
      CLEAR: state_n = LOAD;
      LOAD: begin
        if (In_Valid) begin
          ov_n   = 1'b1;
          od_n   = In_Data;
          beat_n = beat_inc;
          if (beat_inc == k) begin
            state_n = FLUSH;
            flush_n = FW'(N - 1);
          end
        end
      end
      // Outputs are registered, so FLUSH spends one cycle per zero beat plus
      // a final cycle in which the last zero beat is on the bus and Done is
      // loaded for the following cycle.
      FLUSH: begin
        if (flush != '0) begin
          ov_n    = 1'b1;
          flush_n = flush - 1'b1;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (SYNC_RST) begin
      state_n = IDLE;
      k_n     = '0;
      beat_n  = '0;
      flush_n = '0;
      ov_n    = 1'b0;
      sc_n    = 1'b0;
      od_n    = '0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state      <= IDLE;
      k          <= '0;
      beat       <= '0;
      flush      <= '0;
      Out_Valid  <= 1'b0;
      Skew_Clear <= 1'b0;
      Out_Data   <= '0;
      Done       <= 1'b0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      beat       <= beat_n;
      flush      <= flush_n;
      Out_Valid  <= ov_n;
      Skew_Clear <= sc_n;
      Out_Data   <= od_n;
      Done       <= done_n;
    end
  end

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Testbench for systolic_tile_feeder (N=4, DATA_WIDTH=8, K_MAX=256).
module tb_systolic_tile_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KM = 256;
  localparam int CW = $clog2(KM + 1);
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          arst, srst, start, in_valid, in_ready;
  logic          out_valid, skew_clear, busy, done;
  logic [CW-1:0] k_len;
  logic [W-1:0]  in_data, out_data;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic          s;
    logic [CW-1:0] k;
    logic          v;
    logic [W-1:0]  d;
    logic          sr;
    logic          e_rdy, e_ov, e_sc, e_busy, e_done;
    logic [W-1:0]  e_od;
  } vec_t;

  vec_t vq[$];

  // saturation run bookkeeping
  logic [W-1:0] expq[$];
  int nhs, nclr, nzero, dbad, last_hs, done_cyc;

  always #5 clk = ~clk;

  systolic_tile_feeder #(.N(N), .DATA_WIDTH(DW), .K_MAX(KM)) dut (
    .CLK(clk), .ASYNC_RST(arst), .SYNC_RST(srst), .Start(start), .K_Len(k_len),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Data(in_data),
    .Out_Valid(out_valid), .Skew_Clear(skew_clear), .Out_Data(out_data),
    .Busy(busy), .Done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [W+4:0] outs();
    return {in_ready, out_valid, skew_clear, busy, done, out_data};
  endfunction

  function automatic logic [W-1:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b + 8'd1, 8'h80};
  endfunction

  task automatic add(input logic s, input int k, input logic v, input logic [W-1:0] d,
                     input logic sr, input logic rdy, input logic ov, input logic sc,
                     input logic bz, input logic dn, input logic [W-1:0] od);
    vec_t r;
    r.s = s; r.k = CW'(k); r.v = v; r.d = d; r.sr = sr;
    r.e_rdy = rdy; r.e_ov = ov; r.e_sc = sc; r.e_busy = bz; r.e_done = dn; r.e_od = od;
    vq.push_back(r);
  endtask

  // Row i: compare the outputs seen in cycle i, then drive that cycle's inputs.
  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), outs(),
            {vq[i].e_rdy, vq[i].e_ov, vq[i].e_sc, vq[i].e_busy, vq[i].e_done, vq[i].e_od});
      start    = vq[i].s;
      k_len    = vq[i].k;
      in_valid = vq[i].v;
      in_data  = vq[i].d;
      srst     = vq[i].sr;
      tick();
    end
    start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0; srst = 1'b0;
    vq.delete();
  endtask

  initial begin
    arst = 1'b1; srst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;
    #2;
    check("reset_outs", outs(), '0);
    @(negedge clk);
    arst = 1'b0;
    tick();
    check("post_reset_idle", {in_ready, busy}, 2'b00);

    // Basic tile, K=3, with Start pulses while Busy that must be ignored
    add(1, 3, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 32'h01010101, 0, 0, 1, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'h01010101, 0, 1, 0, 0, 1, 0, 32'h0);
    add(1, 1, 1, 32'h02020202, 0, 1, 1, 0, 1, 0, 32'h01010101);
    add(0, 0, 1, 32'h03030303, 0, 1, 1, 0, 1, 0, 32'h02020202);
    add(0, 0, 1, 32'h04040404, 0, 0, 1, 0, 1, 0, 32'h03030303);
    add(1, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    run_table("basic");

    // Backpressure, K=4, In_Valid pattern 1,0,0,1,1,0,1
    add(1, 4, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'h11111111, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 1, 0, 1, 0, 32'h11111111);
    add(0, 0, 0, 32'h0,        0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h22222222, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h33333333, 0, 1, 1, 0, 1, 0, 32'h22222222);
    add(0, 0, 0, 32'h0,        0, 1, 1, 0, 1, 0, 32'h33333333);
    add(0, 0, 1, 32'h44444444, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h55555555, 0, 0, 1, 0, 1, 0, 32'h44444444);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    run_table("backpressure");

    // Empty tile
    add(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
    run_table("empty");

    // Empty tile followed by a Start in its Done cycle, K=1, extreme signed rows
    add(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    add(1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'h80FF7F01, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h80FF7F01);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    run_table("back_to_back");

    // Abort after 2 of 5 beats (SYNC_RST beats a concurrent handshake), then K=2
    add(1, 5, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'h0A0A0A0A, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h0B0B0B0B, 0, 1, 1, 0, 1, 0, 32'h0A0A0A0A);
    add(0, 0, 1, 32'h0C0C0C0C, 1, 1, 1, 0, 1, 0, 32'h0B0B0B0B);
    add(1, 2, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'hA1A1A1A1, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'hB2B2B2B2, 0, 1, 1, 0, 1, 0, 32'hA1A1A1A1);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'hB2B2B2B2);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
    run_table("abort");

    // Saturation: K_Len=300 must yield exactly 256 data beats
    nhs = 0; nclr = 0; nzero = 0; dbad = 0; last_hs = 0; done_cyc = -1;
    start = 1'b1; k_len = CW'(300);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 600 && done_cyc < 0; cyc++) begin
      if (out_valid) begin
        if (skew_clear) nclr++;
        else if (expq.size() > 0) begin
          if (out_data !== expq.pop_front()) dbad++;
        end else if (out_data === '0) nzero++;
        else dbad++;
      end
      if (done) done_cyc = cyc;
      in_valid = 1'b1;
      in_data  = pat(nhs);
      start    = (nhs == 100);
      k_len    = CW'(1);
      if (in_ready) begin
        expq.push_back(pat(nhs));
        nhs++;
        last_hs = cyc;
      end
      tick();
    end
    in_valid = 1'b0; start = 1'b0; k_len = '0;
    check("sat_handshakes", 64'(nhs), 64'd256);
    check("sat_clear_beats", 64'(nclr), 64'd1);
    check("sat_data_errors", 64'(dbad), 64'd0);
    check("sat_pending", 64'(expq.size()), 64'd0);
    check("sat_zero_beats", 64'(nzero), 64'd3);
    check("sat_done_latency", 64'(done_cyc - last_hs), 64'd5);
    check("sat_after_idle", {busy, done, out_valid}, 3'b000);

    // Asynchronous reset in the middle of a cycle carrying a data beat
    start = 1'b1; k_len = CW'(2);
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    check("pre_arst_beat", {out_valid, out_data}, {1'b1, 32'hDEADBEEF});
    #3 arst = 1'b1;
    #1;
    check("arst_mid_cycle", outs(), '0);
    #2 arst = 1'b0;
    tick();
    check("arst_release_1", {in_ready, busy, out_valid}, 3'b000);
    in_valid = 1'b0;
    tick();
    check("arst_release_2", {in_ready, busy, out_valid}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
